// File: rtl/c3lib_prog_tie_bus_lcell_if.sv
// Config/readback bundle for the programmable tie bus.
// C3LIB_PROG_TIE_PARITY_EN adds wr_par (even parity over wr_data) and the sticky par_err flag.
interface c3lib_prog_tie_bus_lcell_if #(
  parameter int WIDTH = 8
);
  // Handshake: a shadow write happens on the clk edge where wr_vld && wr_rdy are both high;
  // wr_rdy is combinational and never depends on wr_vld, and wr_vld may be held until accepted.
  logic             wr_vld;
  logic [WIDTH-1:0] wr_data;
  logic             wr_rdy;
  logic             apply;
  logic             revert;
  logic             lock;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] shadow_q;
  logic             busy;
  logic             locked;
  logic [1:0]       dbg_state;
`ifdef C3LIB_PROG_TIE_PARITY_EN
  logic             wr_par;
  logic             par_err;
`endif

  modport master (
    output wr_vld, wr_data, apply, revert, lock,
`ifdef C3LIB_PROG_TIE_PARITY_EN
    output wr_par,
    input  par_err,
`endif
    input  wr_rdy, out, shadow_q, busy, locked, dbg_state
  );

  modport slave (
    input  wr_vld, wr_data, apply, revert, lock,
`ifdef C3LIB_PROG_TIE_PARITY_EN
    input  wr_par,
    output par_err,
`endif
    output wr_rdy, out, shadow_q, busy, locked, dbg_state
  );
endinterface

// File: rtl/c3lib_prog_tie_bus_lcell.sv
// Programmable tie bus: shadow register committed to a static output after a settle window.
// Optional write parity checking is enabled by defining C3LIB_PROG_TIE_PARITY_EN.
module c3lib_prog_tie_bus_lcell #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TIE_VALUE     = WIDTH'(8'h0F),
  parameter int               SETTLE_CYCLES = 4
) (
  input logic                        clk,
  input logic                        rst,
  c3lib_prog_tie_bus_lcell_if.slave  bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_out;
  logic             r_locked;
  logic             r_par_err;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shadow_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_wr_rdy;
  logic             w_wr_fire;
  logic             w_par_ok;

  assign w_wr_rdy  = (r_state != ST_SETTLE) && !r_locked && !bus.apply && !bus.revert;
  assign w_wr_fire = bus.wr_vld && w_wr_rdy;

`ifdef C3LIB_PROG_TIE_PARITY_EN
  assign w_par_ok = ~^{bus.wr_data, bus.wr_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_out_nxt    = r_out;
    case (r_state)
      ST_IDLE, ST_LOADED: begin
        // revert outranks apply; a write can only fire when neither strobe is high
        if (!r_locked) begin
          if (bus.revert) begin
            w_shadow_nxt = TIE_VALUE;
            w_state_nxt  = ST_LOADED;
          end else if (bus.apply && (r_state == ST_LOADED)) begin
            w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
            w_state_nxt = ST_SETTLE;
          end else if (w_wr_fire && w_par_ok) begin
            w_shadow_nxt = bus.wr_data;
            w_state_nxt  = ST_LOADED;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_out_nxt   = r_shadow;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_shadow  <= TIE_VALUE;
      r_out     <= TIE_VALUE;
      r_locked  <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_shadow  <= w_shadow_nxt;
      r_out     <= w_out_nxt;
      r_locked  <= r_locked | bus.lock;
      r_par_err <= r_par_err | (w_wr_fire & ~w_par_ok);
    end
  end

  assign bus.wr_rdy    = w_wr_rdy;
  assign bus.out       = r_out;
  assign bus.shadow_q  = r_shadow;
  assign bus.busy      = (r_state == ST_SETTLE);
  assign bus.locked    = r_locked;
  assign bus.dbg_state = r_state;
`ifdef C3LIB_PROG_TIE_PARITY_EN
  assign bus.par_err   = r_par_err;
`else
  logic w_unused;
  assign w_unused = r_par_err;
`endif
endmodule
